// File: rtl/rf_dump_unit.sv
// rf_dump_unit
//   Walks every entry of the CPU register file through a combinational read
//   port and streams the contents out as (index, value) beats on a
//   valid/ready interface. While a dump is in progress freeze_o stalls the
//   CPU so the snapshot stays coherent.
//
//   A dump starts on a start_i pulse, or once per reset after END_COUNT
//   cycles when AUTO_START is set.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   start_i       one-cycle dump request
//   rf_addr_o     register-file read address
//   rf_data_i     register-file read data for rf_addr_o (same cycle)
//   freeze_o      high while a dump is running
//   dump_valid_o  beat presented
//   dump_ready_i  sink accepts the beat
//   dump_idx_o    register index of the beat
//   dump_data_o   register value of the beat
//   dump_last_o   beat carries the final register
//   done_o        sticky, set once the final beat is accepted
module rf_dump_unit #(
  parameter int unsigned END_COUNT  = 100,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [4:0]        rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              freeze_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [4:0]        dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [31:0] CNT_MAX  = 32'(END_COUNT);
  localparam logic [31:0] CNT_FIRE = 32'(END_COUNT - 1);
  localparam logic [4:0]  LAST_IDX = 5'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic [4:0]          ptr_q, ptr_d;
  logic                auto_fired_q, auto_fired_d;
  logic                valid_q, valid_d;
  logic [4:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                freeze_q, freeze_d;
  logic                done_q, done_d;

  logic                auto_hit;
  logic                load;
  logic                handshake;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    ptr_d        = ptr_q;
    auto_fired_d = auto_fired_q;
    valid_d      = valid_q;
    idx_d        = idx_q;
    data_d       = data_q;
    freeze_d     = freeze_q;
    done_d       = done_q;
    rf_addr_o    = '0;

    auto_hit  = AUTO_START && !auto_fired_q && (cycle_cnt_q == CNT_FIRE);
    handshake = valid_q && dump_ready_i;
    load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The auto-trigger counter only runs before the auto-dump has fired,
        // and stops at END_COUNT so it can never wrap into a second trigger.
        if (!auto_fired_q && (cycle_cnt_q != CNT_MAX)) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (start_i || auto_hit) begin
          load = 1'b1;
        end
        if (auto_hit) begin
          auto_fired_d = 1'b1;
        end
      end

      S_SEND: begin
        // Index 0 was captured at the trigger; ptr already points at the
        // next register to fetch.
        rf_addr_o = ptr_q;
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            valid_d  = 1'b0;
            freeze_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            data_d = rf_data_i;
            idx_d  = ptr_q;
            ptr_d  = ptr_q + 5'd1;
          end
        end
      end

      S_DONE: begin
        // Only an explicit request restarts; the auto-trigger is one-shot.
        if (start_i) begin
          load = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Trigger: rf_addr_o is 0 in IDLE/DONE, so rf_data_i holds register 0.
    if (load) begin
      data_d   = rf_data_i;
      idx_d    = '0;
      valid_d  = 1'b1;
      ptr_d    = 5'd1;
      freeze_d = 1'b1;
      done_d   = 1'b0;
      state_d  = S_SEND;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cycle_cnt_q  <= '0;
      ptr_q        <= '0;
      auto_fired_q <= 1'b0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      freeze_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      ptr_q        <= ptr_d;
      auto_fired_q <= auto_fired_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      freeze_q     <= freeze_d;
      done_q       <= done_d;
    end
  end

  assign freeze_o     = freeze_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;
  assign done_o       = done_q;
  assign dump_last_o  = valid_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_rf_dump_unit.sv
// tb_rf_dump_unit
//   Two instances share one clock and one register-file model: instance 0
//   has the auto-trigger enabled, instance 1 is start-only. Only one is out
//   of reset at a time. Expected beats come from a snapshot of the register
//   file taken when the dump starts.
module tb_rf_dump_unit;

  localparam int NUM = 32;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        start [2];
  logic        ready [2];
  logic [4:0]  addr  [2];
  logic [31:0] rdata [2];
  logic        frz   [2];
  logic        dv    [2];
  logic [4:0]  di    [2];
  logic [31:0] dd    [2];
  logic        dl    [2];
  logic        dn    [2];

  logic [31:0] reg_file [NUM];

  int cyc    = 0;
  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign rdata[0] = reg_file[addr[0]];
  assign rdata[1] = reg_file[addr[1]];

  rf_dump_unit #(.END_COUNT(100), .AUTO_START(1'b1), .NUM_REGS(NUM), .DATA_W(32)) u_auto (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]),
    .rf_addr_o(addr[0]), .rf_data_i(rdata[0]), .freeze_o(frz[0]),
    .dump_valid_o(dv[0]), .dump_ready_i(ready[0]), .dump_idx_o(di[0]),
    .dump_data_o(dd[0]), .dump_last_o(dl[0]), .done_o(dn[0])
  );

  rf_dump_unit #(.END_COUNT(100), .AUTO_START(1'b0), .NUM_REGS(NUM), .DATA_W(32)) u_man (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]),
    .rf_addr_o(addr[1]), .rf_data_i(rdata[1]), .freeze_o(frz[1]),
    .dump_valid_o(dv[1]), .dump_ready_i(ready[1]), .dump_idx_o(di[1]),
    .dump_data_o(dd[1]), .dump_last_o(dl[1]), .done_o(dn[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at the first cycle a dump's beat 0 is visible. mode 0 holds ready
  // high, mode 1 cycles ready 1,0,0,1. start_at pulses start_i mid-dump.
  // stop_after > 0 returns once that many beats have been accepted.
  task automatic run_dump(input int k, input int mode, input int start_at,
                          input int stop_after);
    logic [31:0] snap [$];
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;
    logic        prev_stall;
    int          nbeats;
    int          t;
    for (int i = 0; i < NUM; i++) snap.push_back(reg_file[i]);
    nbeats     = 0;
    t          = 0;
    prev_stall = 1'b0;
    prev_idx   = '0;
    prev_data  = '0;
    while (!dn[k] && t < 3000 && nbeats != stop_after) begin
      ready[k] = (mode == 0) ? 1'b1 : ((t % 4 == 0) || (t % 4 == 3));
      start[k] = (t == start_at);
      check("valid_held", dv[k], 1);
      check("freeze_high", frz[k], 1);
      if (prev_stall) begin
        check("hold_idx", di[k], prev_idx);
        check("hold_data", dd[k], prev_data);
      end
      if (ready[k]) begin
        if (nbeats < NUM) begin
          check("beat_idx", di[k], nbeats);
          check("beat_data", dd[k], snap[nbeats]);
          check("beat_last", dl[k], (nbeats == NUM - 1));
        end else begin
          check("extra_beat", nbeats, NUM - 1);
        end
        nbeats++;
      end else begin
        check("last_on_stall", dl[k], (nbeats == NUM - 1));
      end
      prev_stall = !ready[k];
      prev_idx   = di[k];
      prev_data  = dd[k];
      step();
      t++;
    end
    start[k] = 1'b0;
    ready[k] = 1'b0;
    if (stop_after < 0) begin
      check("beat_count", nbeats, NUM);
      check("done_after", dn[k], 1);
      check("freeze_after", frz[k], 0);
      check("valid_after", dv[k], 0);
      check("last_after", dl[k], 0);
      if (mode == 0) check("back_to_back", t, NUM);
    end else begin
      check("partial_count", nbeats, stop_after);
    end
  endtask

  task automatic expect_quiet(input int k, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (dv[k] || frz[k]) seen++;
    end
    check("no_refire", seen, 0);
    check("done_sticky", dn[k], 1);
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    check("restart_valid", dv[k], 1);
    check("restart_done_clr", dn[k], 0);
    check("restart_idx0", di[k], 0);
  endtask

  // Releases reset and checks the auto-dump's beat 0 appears at cycle 100.
  task automatic auto_start_at_100(input int k);
    rst[k] = 1'b1;
    cyc = 0;
    step_n(99);
    check("pre_auto_valid", dv[k], 0);
    check("pre_auto_addr", addr[k], 0);
    step();
    check("auto_cycle", cyc, 100);
    check("auto_valid", dv[k], 1);
    check("auto_idx0", di[k], 0);
    check("auto_freeze", frz[k], 1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; start[k] = 1'b0; ready[k] = 1'b0;
    end
    for (int i = 0; i < NUM; i++) reg_file[i] = 32'(i * 3);
    @(negedge clk);
    step_n(2);

    // Reset state
    check("rst_valid", dv[0], 0);
    check("rst_idx", di[0], 0);
    check("rst_data", dd[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_freeze", frz[0], 0);
    check("rst_addr", addr[0], 0);
    check("rst_last", dl[0], 0);

    // Auto-dump with ready tied high
    auto_start_at_100(0);
    run_dump(0, 0, -1, -1);
    expect_quiet(0, 150);

    // Backpressure restart from DONE, with a register written before trigger
    reg_file[5] = 32'hDEADBEEF;
    pulse_start(0);
    run_dump(0, 1, -1, -1);

    // Reset mid-dump after beat 7 is accepted
    pulse_start(0);
    run_dump(0, 0, -1, 8);
    #1;
    rst[0] = 1'b0;
    #1;
    check("abort_valid", dv[0], 0);
    check("abort_idx", di[0], 0);
    check("abort_data", dd[0], 0);
    check("abort_freeze", frz[0], 0);
    check("abort_done", dn[0], 0);
    check("abort_addr", addr[0], 0);
    @(negedge clk);
    auto_start_at_100(0);
    run_dump(0, 0, -1, -1);
    rst[0] = 1'b0;

    // Manual-start instance
    for (int i = 0; i < NUM; i++) reg_file[i] = $urandom;
    rst[1] = 1'b1;
    cyc = 0;
    step_n(10);
    check("man_idle", dv[1], 0);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    check("man_cycle", cyc, 11);
    check("man_valid", dv[1], 1);
    run_dump(1, 0, 10, -1);
    expect_quiet(1, 150);
    for (int i = 0; i < NUM; i++) reg_file[i] = $urandom;
    pulse_start(1);
    run_dump(1, 1, 5, -1);
    rst[1] = 1'b0;

    // start_i coinciding with the auto-trigger cycle
    for (int i = 0; i < NUM; i++) reg_file[i] = $urandom;
    @(negedge clk);
    rst[0] = 1'b1;
    cyc = 0;
    step_n(99);
    check("sim_pre_valid", dv[0], 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("sim_valid", dv[0], 1);
    run_dump(0, 0, -1, -1);
    expect_quiet(0, 150);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
